// File: rtl/code_matcher.sv
// rtl/code_matcher.sv - keypad code entry buffer, compare against master/user/staged codes, lockout
module code_matcher #(
   parameter int                          DIGITS         = 6,
   parameter int                          DIGIT_W        = 4,
   parameter int                          CLEAR_KEY      = 7,
   parameter int                          ENTER_KEY      = 8,
   parameter int                          OPT_DIGITS     = 2,
   parameter logic [DIGITS*DIGIT_W-1:0]   MASTER_CODE    = 24'h666666,
   parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_UC     = 24'h123456,
   parameter int                          MAX_FAILS      = 3,
   parameter int                          LOCKOUT_CYCLES = 12000000
) (
   input  logic                              hwclk,
   input  logic                              reset,
   input  logic                              key_valid,
   input  logic [DIGIT_W-1:0]                key,
   input  logic                              read_en,
   input  logic [1:0]                        mode,
   input  logic                              commit,
   output logic                              result_valid,
   output logic                              result_match,
   output logic                              locked,
   output logic [DIGITS*DIGIT_W-1:0]         user_code,
   output logic [$clog2(DIGITS+1)-1:0]       digit_count
);

   localparam int CODE_W = DIGITS * DIGIT_W;
   localparam int CNT_W  = $clog2(DIGITS + 1);
   localparam int FAIL_W = $clog2(MAX_FAILS + 1);
   localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

   localparam logic [DIGIT_W-1:0] CLEAR_K    = DIGIT_W'(CLEAR_KEY);
   localparam logic [DIGIT_W-1:0] ENTER_K    = DIGIT_W'(ENTER_KEY);
   localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DIGITS);
   localparam logic [FAIL_W-1:0]  FAIL_LAST  = FAIL_W'(MAX_FAILS - 1);
   localparam logic [TMR_W-1:0]   TMR_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);

   localparam logic [1:0] MODE_MASTER  = 2'b00;
   localparam logic [1:0] MODE_USER    = 2'b01;
   localparam logic [1:0] MODE_CONFIRM = 2'b10;
   localparam logic [1:0] MODE_STAGE   = 2'b11;

   typedef enum logic [1:0] {
      ENTRY  = 2'b00,
      EVAL   = 2'b01,
      LOCKED = 2'b10
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [CODE_W-1:0]   entry_buf;
   logic [CODE_W-1:0]   staged_code;
   logic                staged_valid;
   logic [1:0]          eval_mode;
   logic                match_q;
   logic [FAIL_W-1:0]   fail_cnt;
   logic [TMR_W-1:0]    lock_timer;

   logic                key_accept;
   logic                is_clear;
   logic                is_enter;
   logic                enter_go;
   logic                eval_hit;
   logic                counts_fail;
   logic                fail_limit;

   // Stored digits in the top OPT_DIGITS positions that are zero act as wildcards.
   function automatic logic digits_match(input logic [CODE_W-1:0] stored,
                                         input logic [CODE_W-1:0] entered);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if ((stored[i*DIGIT_W +: DIGIT_W] != entered[i*DIGIT_W +: DIGIT_W]) &&
             !((i >= DIGITS - OPT_DIGITS) && (stored[i*DIGIT_W +: DIGIT_W] == '0))) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

   assign key_accept = key_valid & read_en & (state == ENTRY);
   assign is_clear   = (key == CLEAR_K);
   assign is_enter   = (key == ENTER_K);
   assign enter_go   = key_accept & is_enter & (digit_count != '0);

   // The buffer is frozen during EVAL, so it still holds the code being judged.
   always_comb begin
      eval_hit = 1'b0;
      case (eval_mode)
         MODE_MASTER:  eval_hit = (entry_buf == MASTER_CODE);
         MODE_USER:    eval_hit = digits_match(user_code, entry_buf);
         MODE_CONFIRM: eval_hit = staged_valid & digits_match(staged_code, entry_buf);
         default:      eval_hit = 1'b1;
      endcase
   end

   assign counts_fail = (eval_mode != MODE_STAGE) & ~eval_hit;
   assign fail_limit  = counts_fail & (fail_cnt == FAIL_LAST);

   always_ff @(posedge hwclk or posedge reset) begin
      if (reset) begin
         state <= ENTRY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ENTRY:   if (enter_go) state_nxt = EVAL;
         EVAL:    state_nxt = fail_limit ? LOCKED : ENTRY;
         LOCKED:  if (lock_timer == '0) state_nxt = ENTRY;
         default: state_nxt = ENTRY;
      endcase
   end

   assign result_valid = (state == EVAL);
   assign result_match = (state == EVAL) ? eval_hit : match_q;
   assign locked       = (state == LOCKED);

   always_ff @(posedge hwclk or posedge reset) begin
      if (reset) begin
         entry_buf    <= '0;
         digit_count  <= '0;
         eval_mode    <= MODE_MASTER;
         match_q      <= 1'b0;
         fail_cnt     <= '0;
         lock_timer   <= '0;
         staged_code  <= '0;
         staged_valid <= 1'b0;
         user_code    <= DEFAULT_UC;
      end else begin
         if (key_accept) begin
            if (is_clear) begin
               entry_buf   <= '0;
               digit_count <= '0;
            end else if (!is_enter) begin
               entry_buf <= {entry_buf[CODE_W-DIGIT_W-1:0], key};
               if (digit_count != CNT_FULL) begin
                  digit_count <= digit_count + CNT_W'(1);
               end
            end else if (enter_go) begin
               eval_mode <= mode;
            end
         end

         if (state == EVAL) begin
            entry_buf   <= '0;
            digit_count <= '0;
            match_q     <= eval_hit;
            if (eval_mode != MODE_STAGE) begin
               fail_cnt <= eval_hit ? '0 : fail_cnt + FAIL_W'(1);
            end
            if (fail_limit) begin
               lock_timer <= TMR_LOAD;
            end
         end

         if (state == LOCKED) begin
            if (lock_timer == '0) begin
               fail_cnt <= '0;
            end else begin
               lock_timer <= lock_timer - TMR_W'(1);
            end
         end

         if (commit && staged_valid && (state != LOCKED)) begin
            user_code    <= staged_code;
            staged_valid <= 1'b0;
         end

         // Written after commit so a same-cycle commit takes the old staged value.
         if ((state == EVAL) && (eval_mode == MODE_STAGE)) begin
            staged_code  <= entry_buf;
            staged_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_code_matcher.sv
// tb/tb_code_matcher.sv - randomized self-checking bench for code_matcher against a digit-level model
module tb_code_matcher;

   localparam int LOCK = 20;

   logic        hwclk = 1'b0;
   logic        reset;
   logic        key_valid;
   logic [3:0]  key;
   logic        read_en;
   logic [1:0]  mode;
   logic        commit;
   logic        result_valid;
   logic        result_match;
   logic        locked;
   logic [23:0] user_code;
   logic [2:0]  digit_count;

   code_matcher #(.LOCKOUT_CYCLES(LOCK)) dut (
      .hwclk        (hwclk),
      .reset        (reset),
      .key_valid    (key_valid),
      .key          (key),
      .read_en      (read_en),
      .mode         (mode),
      .commit       (commit),
      .result_valid (result_valid),
      .result_match (result_match),
      .locked       (locked),
      .user_code    (user_code),
      .digit_count  (digit_count)
   );

   always #5 hwclk = ~hwclk;

   int checks   = 0;
   int failures = 0;

   logic [23:0] m_buf, m_user, m_staged;
   int          m_cnt, m_fails;
   bit          m_sv, m_lock, m_match;
   bit          hold_lock = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge hwclk);
      #1;
   endtask

   function automatic int digit_of(input logic [23:0] v, input int i);
      return int'((v >> (4 * i)) & 24'hF);
   endfunction

   function automatic bit code_eq(input logic [23:0] stored, input logic [23:0] entered);
      for (int i = 0; i < 6; i++) begin
         if (digit_of(stored, i) != digit_of(entered, i) && !(i >= 4 && digit_of(stored, i) == 0))
            return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_buf = '0; m_cnt = 0; m_user = 24'h123456; m_staged = '0; m_sv = 1'b0;
      m_fails = 0; m_lock = 1'b0; m_match = 1'b0;
   endtask

   task automatic model_eval(output bit hit);
      case (mode)
         2'b00: hit = (m_buf == 24'h666666);
         2'b01: hit = code_eq(m_user, m_buf);
         2'b10: hit = m_sv && code_eq(m_staged, m_buf);
         default: begin hit = 1'b1; m_staged = m_buf; m_sv = 1'b1; end
      endcase
      if (mode != 2'b11) begin
         if (hit) m_fails = 0;
         else begin
            m_fails++;
            if (m_fails == 3) m_lock = 1'b1;
         end
      end
      m_match = hit;
   endtask

   task automatic wait_lockout();
      int n;
      n = 1;
      key_valid = 1'b1; key = 4'd5; commit = 1'b1;
      while (locked && n < 200) begin
         tick();
         if (locked) n++;
      end
      key_valid = 1'b0; commit = 1'b0;
      check("lock_len", 32'(n), 32'(LOCK));
      check("lock_cnt", 32'(digit_count), 32'd0);
      check("lock_uc", 32'(user_code), 32'(m_user));
      m_lock = 1'b0; m_fails = 0;
   endtask

   task automatic press(input logic [3:0] k);
      bit hit;
      key = k; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      if (k == 4'd7) begin
         m_buf = '0; m_cnt = 0;
         check("clr_cnt", 32'(digit_count), 32'd0);
         check("clr_rv", 32'(result_valid), 32'd0);
      end else if (k == 4'd8) begin
         if (m_cnt == 0) begin
            check("empty_rv", 32'(result_valid), 32'd0);
         end else begin
            model_eval(hit);
            check("rv", 32'(result_valid), 32'd1);
            check("match", 32'(result_match), 32'(hit));
            tick();
            m_buf = '0; m_cnt = 0;
            check("rv_pulse", 32'(result_valid), 32'd0);
            check("cnt_after", 32'(digit_count), 32'd0);
            check("match_hold", 32'(result_match), 32'(m_match));
            check("locked", 32'(locked), 32'(m_lock));
            if (m_lock && !hold_lock) wait_lockout();
         end
      end else begin
         m_buf = {m_buf[19:0], k};
         m_cnt = (m_cnt < 6) ? m_cnt + 1 : 6;
         check("cnt", 32'(digit_count), 32'(m_cnt));
         check("dig_rv", 32'(result_valid), 32'd0);
      end
   endtask

   task automatic press_noread(input logic [3:0] k);
      read_en = 1'b0; key = k; key_valid = 1'b1;
      tick();
      key_valid = 1'b0; read_en = 1'b1;
      check("noread_cnt", 32'(digit_count), 32'(m_cnt));
   endtask

   task automatic enter_val(input logic [23:0] v, input logic [1:0] md);
      mode = md;
      for (int i = 5; i >= 0; i--) press(v[4*i +: 4]);
      press(4'd8);
   endtask

   task automatic do_commit();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      if (m_sv) begin m_user = m_staged; m_sv = 1'b0; end
      check("commit_uc", 32'(user_code), 32'(m_user));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_rv", 32'(result_valid), 32'd0);
      check("rst_match", 32'(result_match), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_cnt", 32'(digit_count), 32'd0);
      check("rst_uc", 32'(user_code), 32'h123456);
      key_valid = 1'b0; commit = 1'b0;
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   function automatic logic [3:0] rand_digit();
      int d;
      do d = $urandom_range(0, 15); while (d == 7 || d == 8);
      return 4'(d);
   endfunction

   task automatic rand_entry();
      logic [1:0]  md;
      logic [23:0] tgt;
      int          n;
      md = 2'($urandom_range(0, 3));
      mode = md;
      if ($urandom_range(0, 1) == 1) begin
         tgt = (md == 2'b00) ? 24'h666666 : (md == 2'b01) ? m_user : m_staged;
         for (int i = 5; i >= 0; i--) press(tgt[4*i +: 4]);
      end else begin
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 11) == 0) press(4'd7);
            else press(rand_digit());
         end
      end
      press(4'd8);
   endtask

   initial begin
      reset = 1'b1; key_valid = 1'b0; key = '0; read_en = 1'b1; mode = '0; commit = 1'b0;
      tick();
      do_reset();

      enter_val(24'h123456, 2'b01);

      enter_val(24'h003456, 2'b11);
      do_commit();
      enter_val(24'h993456, 2'b01);
      enter_val(24'h103456, 2'b11);
      do_commit();
      enter_val(24'h993456, 2'b01);

      enter_val(24'h246135, 2'b11);
      enter_val(24'h246135, 2'b10);
      do_commit();
      check("uc_246135", 32'(user_code), 32'h246135);
      enter_val(24'h246135, 2'b01);

      for (int i = 0; i < 3; i++) enter_val(24'h111111, 2'b00);
      enter_val(24'h666666, 2'b00);

      mode = 2'b01;
      for (int i = 0; i < 8; i++) press(4'(i == 7 ? 9 : i));
      press_noread(4'd3);
      press(4'd7);
      press(4'd8);

      press(4'd1);
      press(4'd2);
      do_reset();

      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 9))
            0:       do_commit();
            1:       press_noread(rand_digit());
            default: rand_entry();
         endcase
      end

      hold_lock = 1'b1;
      for (int i = 0; i < 3; i++) enter_val(24'h121212, 2'b00);
      for (int i = 0; i < 5; i++) tick();
      check("midlock", 32'(locked), 32'd1);
      do_reset();
      hold_lock = 1'b0;
      enter_val(24'h123456, 2'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
